id_exe_reg: RTL and testbench

- ID→EXE pipeline register of the 5-stage MIPS core; directly downstream of the ID hazard checker (idready).
- Consumes its `ready` output: a decoded instruction is issued into EXE only when there is no hazard and EXE can accept it. Otherwise a bubble is inserted.
- Feeds `exe_write_type` and `exe_wnum` back to the hazard checker.
- Also keeps a saturating hazard-bubble counter for performance analysis.

---
 rtl/cpu_defs_pkg.sv | 19 +
 rtl/sat_counter.sv | 34 +++
 rtl/id_exe_reg.sv | 104 ++++++++++
 tb/tb_id_exe_reg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: writeback-class encodings, field widths and the
// ID/EXE register occupancy states.
package cpu_defs;

    localparam int unsigned ALUOP_W   = 12;
    localparam int unsigned REG_NUM_W = 5;
    localparam int unsigned WT_W      = 3;

    localparam logic [WT_W-1:0] WT_NONE = 3'b000;
    localparam logic [WT_W-1:0] WT_WB   = 3'b001;
    localparam logic [WT_W-1:0] WT_MEM  = 3'b010;
    localparam logic [WT_W-1:0] WT_EXE  = 3'b100;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } exe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register: issues only hazard-free instructions, inserts
// bubbles otherwise, and counts hazard-bubble cycles.
module id_exe_reg
    import cpu_defs::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ALUOP_W = cpu_defs::ALUOP_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic                 id_hazard_ready,
    input  logic [DATA_W-1:0]    id_pc,
    input  logic [DATA_W-1:0]    id_inst,
    input  logic [ALUOP_W-1:0]   id_alu_op,
    input  logic [DATA_W-1:0]    id_src1,
    input  logic [DATA_W-1:0]    id_src2,
    input  logic [WT_W-1:0]      id_write_type,
    input  logic [REG_NUM_W-1:0] id_wnum,
    output logic                 id_allowin,
    output logic                 id_fire,
    input  logic                 exe_allowin,
    output logic                 exe_valid,
    output logic [DATA_W-1:0]    exe_pc,
    output logic [DATA_W-1:0]    exe_inst,
    output logic [ALUOP_W-1:0]   exe_alu_op,
    output logic [DATA_W-1:0]    exe_src1,
    output logic [DATA_W-1:0]    exe_src2,
    output logic [WT_W-1:0]      exe_write_type,
    output logic [REG_NUM_W-1:0] exe_wnum,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     bubble_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    inst;
        logic [ALUOP_W-1:0]   alu_op;
        logic [DATA_W-1:0]    src1;
        logic [DATA_W-1:0]    src2;
        logic [WT_W-1:0]      wt;
        logic [REG_NUM_W-1:0] wnum;
    } payload_t;

    exe_state_t state_q;
    exe_state_t state_d;
    payload_t   pl_q;
    payload_t   pl_d;
    logic       valid_q;
    logic       exe_fire;
    logic       bubble_inc;

    assign valid_q    = (state_q == FULL);
    assign exe_fire   = valid_q & exe_allowin;
    assign id_allowin = !valid_q | exe_fire;
    assign id_fire    = id_valid & id_hazard_ready & id_allowin & !flush;
    assign bubble_inc = id_valid & id_allowin & !id_hazard_ready & !flush;

    // Flush dominates; otherwise a free slot takes either the issue or a bubble.
    always_comb begin
        state_d = state_q;
        pl_d    = pl_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (id_allowin) begin
            state_d = id_fire ? FULL : EMPTY;
        end
        if (id_fire) begin
            pl_d = '{pc: id_pc, inst: id_inst, alu_op: id_alu_op, src1: id_src1,
                     src2: id_src2, wt: id_write_type, wnum: id_wnum};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            pl_q    <= pl_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (bubble_inc),
        .clr    (cnt_clr),
        .cnt    (bubble_cnt)
    );

    assign exe_valid      = valid_q;
    assign exe_pc         = pl_q.pc;
    assign exe_inst       = pl_q.inst;
    assign exe_alu_op     = pl_q.alu_op;
    assign exe_src1       = pl_q.src1;
    assign exe_src2       = pl_q.src2;
    // Empty slots must never look like a pending write to the hazard checker.
    assign exe_write_type = valid_q ? pl_q.wt : WT_NONE;
    assign exe_wnum       = pl_q.wnum;

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: the driver queues per-cycle and per-issue
// expectations, a negedge monitor pops and compares them.
module tb_id_exe_reg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ALUOP_W = 12;
    localparam int unsigned CNT_W   = 4;

    logic               clk = 1'b0;
    logic               resetn;
    logic               flush;
    logic               id_valid;
    logic               id_hazard_ready;
    logic [DATA_W-1:0]  id_pc;
    logic [DATA_W-1:0]  id_inst;
    logic [ALUOP_W-1:0] id_alu_op;
    logic [DATA_W-1:0]  id_src1;
    logic [DATA_W-1:0]  id_src2;
    logic [2:0]         id_write_type;
    logic [4:0]         id_wnum;
    logic               id_allowin;
    logic               id_fire;
    logic               exe_allowin;
    logic               exe_valid;
    logic [DATA_W-1:0]  exe_pc;
    logic [DATA_W-1:0]  exe_inst;
    logic [ALUOP_W-1:0] exe_alu_op;
    logic [DATA_W-1:0]  exe_src1;
    logic [DATA_W-1:0]  exe_src2;
    logic [2:0]         exe_write_type;
    logic [4:0]         exe_wnum;
    logic               cnt_clr;
    logic [CNT_W-1:0]   bubble_cnt;

    id_exe_reg #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_hazard_ready (id_hazard_ready),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_alu_op       (id_alu_op),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_write_type   (id_write_type),
        .id_wnum         (id_wnum),
        .id_allowin      (id_allowin),
        .id_fire         (id_fire),
        .exe_allowin     (exe_allowin),
        .exe_valid       (exe_valid),
        .exe_pc          (exe_pc),
        .exe_inst        (exe_inst),
        .exe_alu_op      (exe_alu_op),
        .exe_src1        (exe_src1),
        .exe_src2        (exe_src2),
        .exe_write_type  (exe_write_type),
        .exe_wnum        (exe_wnum),
        .cnt_clr         (cnt_clr),
        .bubble_cnt      (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        allowin;
        logic        fire;
        logic        valid;
        logic [2:0]  wt;
        logic [3:0]  cnt;
        logic        chk_pc;
        logic [31:0] pc;
        logic        kill;
    } cyc_exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  wt;
        logic [4:0]  wnum;
    } txn_t;

    cyc_exp_t cq[$];
    txn_t     tq[$];
    cyc_exp_t e;
    txn_t     t;
    int       tests = 0;
    int       fails = 0;
    logic     done  = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: per-cycle control/status checks and in-order payload checks.
    always @(negedge clk) begin
        if (cq.size() > 0) begin
            e = cq.pop_front();
            chk("id_allowin", 32'(id_allowin), 32'(e.allowin));
            chk("id_fire", 32'(id_fire), 32'(e.fire));
            chk("exe_valid", 32'(exe_valid), 32'(e.valid));
            chk("exe_write_type", 32'(exe_write_type), 32'(e.wt));
            chk("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
            if (e.chk_pc) chk("exe_pc_held", exe_pc, e.pc);
            if (e.kill && tq.size() > 0) void'(tq.pop_front());
        end
        if (exe_valid && exe_allowin && !flush && resetn) begin
            if (tq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: got pc %h expected no entry", exe_pc);
            end else begin
                t = tq.pop_front();
                chk("issue_pc", exe_pc, t.pc);
                chk("issue_inst", exe_inst, ~t.pc);
                chk("issue_alu_op", 32'(exe_alu_op), 32'(t.pc[11:0]));
                chk("issue_src1", exe_src1, t.pc + 32'd1);
                chk("issue_src2", exe_src2, t.pc + 32'd2);
                chk("issue_wt", 32'(exe_write_type), 32'(t.wt));
                chk("issue_wnum", 32'(exe_wnum), 32'(t.wnum));
            end
        end
        if (done) begin
            chk("scoreboard_drained", 32'(tq.size()), 32'd0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic drv(input logic v, input logic hz, input logic ea, input logic fl,
                       input logic clr, input logic [31:0] pc, input logic [2:0] wt,
                       input logic [4:0] wn);
        @(posedge clk);
        #1;
        id_valid        = v;
        id_hazard_ready = hz;
        exe_allowin     = ea;
        flush           = fl;
        cnt_clr         = clr;
        id_pc           = pc;
        id_inst         = ~pc;
        id_alu_op       = pc[11:0];
        id_src1         = pc + 32'd1;
        id_src2         = pc + 32'd2;
        id_write_type   = wt;
        id_wnum         = wn;
    endtask

    task automatic expc(input logic al, input logic fi, input logic va, input logic [2:0] wt,
                        input logic [3:0] cnt, input logic cp, input logic [31:0] pc,
                        input logic kill);
        cyc_exp_t x;
        x.allowin = al; x.fire = fi; x.valid = va; x.wt = wt; x.cnt = cnt;
        x.chk_pc = cp; x.pc = pc; x.kill = kill;
        cq.push_back(x);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [2:0] wt, input logic [4:0] wn);
        txn_t x;
        x.pc = pc; x.wt = wt; x.wnum = wn;
        tq.push_back(x);
    endtask

    initial begin
        resetn = 1'b0;
        drv(0, 0, 0, 0, 0, 32'h0, 3'b000, 5'd0);
        expc(1, 0, 0, 3'b000, 4'd0, 1, 32'h0, 0);

        // Back-to-back stream, one issue per cycle
        drv(1, 1, 1, 0, 0, 32'hBFC00000, 3'b001, 5'd1);
        resetn = 1'b1;
        expc(1, 1, 0, 3'b000, 4'd0, 0, 32'h0, 0);
        issue(32'hBFC00000, 3'b001, 5'd1);
        drv(1, 1, 1, 0, 0, 32'hBFC00004, 3'b100, 5'd2);
        expc(1, 1, 1, 3'b001, 4'd0, 1, 32'hBFC00000, 0);
        issue(32'hBFC00004, 3'b100, 5'd2);
        drv(1, 1, 1, 0, 0, 32'hBFC00008, 3'b010, 5'd3);
        expc(1, 1, 1, 3'b100, 4'd0, 1, 32'hBFC00004, 0);
        issue(32'hBFC00008, 3'b010, 5'd3);

        // Three hazard cycles, then issue
        drv(1, 0, 1, 0, 0, 32'h00000100, 3'b001, 5'd4);
        expc(1, 0, 1, 3'b010, 4'd0, 1, 32'hBFC00008, 0);
        drv(1, 0, 1, 0, 0, 32'h00000100, 3'b001, 5'd4);
        expc(1, 0, 0, 3'b000, 4'd1, 0, 32'h0, 0);
        drv(1, 0, 1, 0, 0, 32'h00000100, 3'b001, 5'd4);
        expc(1, 0, 0, 3'b000, 4'd2, 0, 32'h0, 0);
        drv(1, 1, 1, 0, 0, 32'h00000100, 3'b001, 5'd4);
        expc(1, 1, 0, 3'b000, 4'd3, 0, 32'h0, 0);
        issue(32'h00000100, 3'b001, 5'd4);

        // EXE stall for two cycles, issue when it frees up
        drv(1, 1, 0, 0, 0, 32'h00000200, 3'b100, 5'd5);
        expc(0, 0, 1, 3'b001, 4'd3, 1, 32'h00000100, 0);
        drv(1, 1, 0, 0, 0, 32'h00000200, 3'b100, 5'd5);
        expc(0, 0, 1, 3'b001, 4'd3, 1, 32'h00000100, 0);
        drv(1, 1, 1, 0, 0, 32'h00000200, 3'b100, 5'd5);
        expc(1, 1, 1, 3'b001, 4'd3, 1, 32'h00000100, 0);
        issue(32'h00000200, 3'b100, 5'd5);

        // Flush while FULL with issue conditions true, then flush during a hazard
        drv(1, 1, 1, 1, 0, 32'h00000300, 3'b001, 5'd6);
        expc(1, 0, 1, 3'b100, 4'd3, 1, 32'h00000200, 1);
        drv(1, 0, 1, 1, 0, 32'h00000300, 3'b001, 5'd6);
        expc(1, 0, 0, 3'b000, 4'd3, 1, 32'h00000200, 0);
        // No ID instruction: hazard_ready ignored
        drv(0, 0, 1, 0, 0, 32'h00000300, 3'b001, 5'd6);
        expc(1, 0, 0, 3'b000, 4'd3, 1, 32'h00000200, 0);

        // Saturation of the 4-bit counter
        for (int j = 0; j < 20; j++) begin
            drv(1, 0, 1, 0, 0, 32'h00000400, 3'b001, 5'd8);
            expc(1, 0, 0, 3'b000, (j + 3 > 15) ? 4'd15 : 4'(j + 3), 0, 32'h0, 0);
        end
        drv(1, 0, 1, 0, 1, 32'h00000400, 3'b001, 5'd8);
        expc(1, 0, 0, 3'b000, 4'd15, 0, 32'h0, 0);
        drv(1, 0, 1, 0, 0, 32'h00000400, 3'b001, 5'd8);
        expc(1, 0, 0, 3'b000, 4'd0, 0, 32'h0, 0);

        // Reset mid-operation while FULL
        drv(1, 1, 0, 0, 0, 32'hBFC00010, 3'b001, 5'd7);
        expc(1, 1, 0, 3'b000, 4'd1, 0, 32'h0, 0);
        issue(32'hBFC00010, 3'b001, 5'd7);
        drv(0, 0, 0, 0, 0, 32'h0, 3'b000, 5'd0);
        expc(0, 0, 1, 3'b001, 4'd1, 1, 32'hBFC00010, 0);
        drv(0, 0, 0, 0, 0, 32'h0, 3'b000, 5'd0);
        resetn = 1'b0;
        expc(1, 0, 0, 3'b000, 4'd0, 1, 32'h0, 1);
        drv(0, 0, 1, 0, 0, 32'h0, 3'b000, 5'd0);
        resetn = 1'b1;
        expc(1, 0, 0, 3'b000, 4'd0, 1, 32'h0, 0);

        drv(0, 0, 1, 0, 0, 32'h0, 3'b000, 5'd0);
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus expected completion");
        $fatal(1, "timeout");
    end

endmodule
